// File: rtl/data_frame_rx_pkg.sv
// Shared constants for the 3-word Data_FSM frame link.
// The TX side uses the same encodings.
package data_frame_rx_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int FRAME_WORDS    = 3;
  localparam logic [3:0] KEEP_ALL = 4'hF;

  typedef enum logic [1:0] {
    W0      = 2'd0,
    W1      = 2'd1,
    W2      = 2'd2,
    DISCARD = 2'd3
  } rx_state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_LONG  = 2'b10;
  localparam logic [1:0] ERR_KEEP  = 2'b11;

endpackage

// File: rtl/data_frame_rx_sat_counter.sv
// Frame counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/data_frame_rx.sv
// Receive side of the 3-word frame link: unpacks good frames atomically,
// drops and classifies malformed ones, and counts both.
module data_frame_rx
  import data_frame_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  input  logic [DATA_WIDTH/8-1:0] s_keep,
  output logic                    s_ready,
  input  logic                    hold,
  output logic [DATA_WIDTH-1:0]   data_1,
  output logic [DATA_WIDTH-1:0]   data_2,
  output logic [DATA_WIDTH-1:0]   data_3,
  output logic                    frame_done,
  output logic                    frame_err,
  output logic [1:0]              err_code,
  output logic [CNT_WIDTH-1:0]    frame_cnt,
  output logic [CNT_WIDTH-1:0]    err_cnt
);

  rx_state_t             state;
  logic [DATA_WIDTH-1:0] shadow [FRAME_WORDS-1];
  logic                  keep_bad;
  logic                  keep_bad_now;
  logic                  beat;
  logic                  commit;
  logic                  drop;

  assign s_ready      = reset & ~hold;
  assign beat         = s_valid & s_ready;
  assign keep_bad_now = keep_bad | ~(&s_keep);

  // Commit/drop decided on the final beat so counters and pulses share an edge.
  always_comb begin
    commit = 1'b0;
    drop   = 1'b0;
    if (beat && s_last) begin
      case (state)
        W0, W1:  drop = 1'b1;
        W2: begin
          if (keep_bad_now) drop   = 1'b1;
          else              commit = 1'b1;
        end
        DISCARD: drop = 1'b1;
        default: drop = 1'b0;
      endcase
    end
  end

  // The third word goes straight from the stream to data_3, so only two
  // shadow words are needed to make the commit atomic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= W0;
      keep_bad   <= 1'b0;
      for (int i = 0; i < FRAME_WORDS - 1; i++) shadow[i] <= '0;
      data_1     <= '0;
      data_2     <= '0;
      data_3     <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      frame_done <= commit;
      frame_err  <= drop;
      if (beat) begin
        case (state)
          W0: begin
            shadow[0] <= s_data;
            keep_bad  <= ~(&s_keep);
            if (s_last) err_code <= ERR_SHORT;
            else        state    <= W1;
          end
          W1: begin
            shadow[1] <= s_data;
            keep_bad  <= keep_bad_now;
            if (s_last) begin
              err_code <= ERR_SHORT;
              state    <= W0;
            end else begin
              state    <= W2;
            end
          end
          W2: begin
            if (s_last) begin
              if (keep_bad_now) begin
                err_code <= ERR_KEEP;
              end else begin
                data_1 <= shadow[0];
                data_2 <= shadow[1];
                data_3 <= s_data;
              end
              state <= W0;
            end else begin
              state <= DISCARD;
            end
          end
          DISCARD: begin
            if (s_last) begin
              err_code <= ERR_LONG;
              state    <= W0;
            end
          end
          default: state <= W0;
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_WIDTH)) u_good_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (commit),
    .cnt   (frame_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (drop),
    .cnt   (err_cnt)
  );

endmodule
